replay_sequencer_mc: RTL and testbench
======================================

REPLAY_SEQUENCER_MC -- requirements
Module: replay_sequencer_mc

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of independent replay channels (legal range 1..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 19, meaning the memory word address width (QDR address).
REQ-003 The block SHALL have parameter COUNT_WIDTH, default 32, meaning the replay and loop counter width.
REQ-004 The block SHALL have port axi_aclk, input, width 1: the single clock; one clock, reset is synchronous and active-high.
REQ-005 The block SHALL have port axi_rst, input, width 1: synchronous, active-high reset.
REQ-006 The block SHALL have port ch_addr_low, input, width NUM_CH*ADDR_WIDTH: per-channel first word address; channel i uses slice i.
REQ-007 The block SHALL have port ch_addr_high, input, width NUM_CH*ADDR_WIDTH: per-channel last word address, inclusive.
REQ-008 The block SHALL have port ch_replay_count, input, width NUM_CH*COUNT_WIDTH: passes to replay; 0 means infinite.
REQ-009 The block SHALL have port ch_start, input, width NUM_CH: one-cycle start pulse per channel.
REQ-010 The block SHALL have port ch_stop, input, width NUM_CH: one-cycle abort pulse per channel.
REQ-011 The block SHALL have ports ch_busy, ch_done and ch_err, each output, width NUM_CH, giving per-channel status.
REQ-012 The block SHALL have port ch_loops, output, width NUM_CH*COUNT_WIDTH: completed passes since the last start.
REQ-013 The block SHALL have ports mem_rd_valid (output, width 1) and mem_rd_ready (input, width 1), forming the read-request handshake.
REQ-014 The block SHALL have ports mem_rd_addr (output, width ADDR_WIDTH), mem_rd_ch (output, width clog2(NUM_CH), minimum 1) and mem_rd_last (output, width 1: last word of a pass).

Function
REQ-015 Start pulse on a channel that is idle and has low<=high SHALL set busy=1, done=0, err=0 and loops=0, latch replay_count, and mark the channel pending.
REQ-016 Start pulse on an idle channel with low>high SHALL set err=1 and done=1, leave busy=0, and issue no requests.
REQ-017 Start pulse on a busy channel SHALL be ignored.
REQ-018 Start and stop pulses on the same channel in the same cycle SHALL resolve as stop-wins: no state change on an idle channel.
REQ-019 The sequencer FSM SHALL have two states, IDLE and ISSUE.
REQ-020 In IDLE, if any channel is pending, the FSM SHALL grant one round-robin, starting from the channel after the last grant, load addr=low, and enter ISSUE.
REQ-021 In ISSUE, the block SHALL drive mem_rd_valid=1 with addr, ch and last = (addr==high).
REQ-022 Once asserted, mem_rd_valid and all request fields SHALL stay stable until mem_rd_ready=1.
REQ-023 On a handshake with addr!=high, the block SHALL set addr<=addr+1 and remain in ISSUE with the same grant.
REQ-024 On a handshake with addr==high (pass end), loops SHALL increment, saturating at all-ones.
REQ-025 At pass end, if count!=0 and the new loops==count, the channel SHALL become finished (busy=0, done=1) and the FSM SHALL return to IDLE.
REQ-026 At pass end with more passes remaining, the grant SHALL be released: the FSM returns to IDLE and the channel stays pending, so channels interleave per pass.
REQ-027 Stop on a pending, ungranted channel SHALL clear pending and set busy=0, done=1 in the next cycle.
REQ-028 Stop on the granted channel SHALL be latched; the in-flight beat completes unchanged, no further beats are issued, loops is not incremented for the partial pass, and then busy=0, done=1.
REQ-029 Latency: start in cycle N on an idle sequencer SHALL give pending at N+1, grant at N+1, and mem_rd_valid=1 at N+2.
REQ-030 Back-to-back handshakes SHALL sustain one word per cycle within a pass.
REQ-031 There SHALL be one idle cycle between passes for re-arbitration.
REQ-032 Address arithmetic SHALL be ADDR_WIDTH unsigned; low==high SHALL give one-word passes with last=1 on every beat.

Reset
REQ-033 While axi_rst=1, all outputs SHALL be 0 at the next edge (mem_rd_valid dropped even mid-handshake), the FSM SHALL be IDLE, pending SHALL be cleared, and the round-robin pointer SHALL select channel 0.
REQ-034 Reset SHALL override start and stop pulses in the same cycle.

Structure
REQ-035 A shared package replay_seq_pkg SHALL hold the FSM state enum, the CH_IDX_W=clog2(NUM_CH) helper function, and the saturating-increment function.
REQ-036 One sub-module, rr_arbiter (NUM_CH requests, one-hot grant, pointer advance on accept), SHALL be instantiated.
REQ-037 The remaining logic SHALL be inline.

Verification
REQ-038 NUM_CH=4, ch0 low=0x10 high=0x13 count=2, ready=1 -> addresses 10,11,12,13,(idle),10,11,12,13; last on 13; loops=2; done0=1 at end.
REQ-039 ch1 and ch2 started together, count=2 each, one-word regions -> requests alternate ch1, ch2, ch1, ch2.
REQ-040 ready held 0 for 5 cycles mid-pass -> valid, addr and ch constant throughout; no word skipped or repeated.
REQ-041 count=0 on ch3, stop pulsed at addr 0x22 while valid and not ready -> beat 0x22 completes, nothing further, loops unchanged, done3=1.
REQ-042 Start with low=0x30 high=0x2F -> err=1, done=1, and no mem_rd_valid.
REQ-043 axi_rst asserted mid-pass with valid=1 -> valid=0 and all status=0 next cycle; a new start resumes from low.

Source files
------------

// File: rtl/replay_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : replay_seq_pkg
//  Description : Shared types and helpers for the replay sequencer.
//                - seq_state_e : two-state issue FSM encoding
//                - ch_idx_w()  : channel index width, never below 1 bit
//                - sat_inc()   : saturating increment of a W-bit counter
//  Revision    : 1.0 - initial release
// ============================================================================
package replay_seq_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

    // A single channel still needs a 1-bit index so ports never collapse
    // to zero width.
    function automatic int ch_idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter is carried in a 64-bit container; w selects the live width.
    // The value holds once all w low bits are set.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        return (v == mask) ? v : (v + 64'd1);
    endfunction

endpackage : replay_seq_pkg
`default_nettype wire

// File: rtl/replay_sequencer_mc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter, N requesters, one-hot grant.
//                Search starts at r_ptr; on accept the pointer moves to the
//                requester after the one granted.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_req[N]      - request vector
//                i_accept      - grant is being taken this cycle
//                o_valid       - at least one request present
//                o_grant[N]    - one-hot grant
//                o_grant_idx   - binary index of the grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [N-1:0]     i_req,
    input  wire logic             i_accept,
    output logic                  o_valid,
    output logic [N-1:0]          o_grant,
    output logic [IDX_W-1:0]      o_grant_idx
);

    logic [IDX_W-1:0] r_ptr;
    int               w_t;

    always_comb begin
        o_valid     = 1'b0;
        o_grant     = '0;
        o_grant_idx = '0;
        w_t         = 0;
        for (int k = 0; k < N; k++) begin
            // Wrap explicitly so non-power-of-two N works.
            w_t = int'(r_ptr) + k;
            if (w_t >= N) w_t = w_t - N;
            if (!o_valid && i_req[w_t]) begin
                o_valid     = 1'b1;
                o_grant[w_t] = 1'b1;
                o_grant_idx = IDX_W'(w_t);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept && o_valid) begin
            r_ptr <= (int'(o_grant_idx) == N - 1) ? '0 : (o_grant_idx + 1'b1);
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/replay_sequencer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : replay_sequencer_mc
//  Description : Multi-channel memory replay sequencer. Each channel replays
//                the word range [low, high] replay_count times (0 = forever).
//                Channels are arbitrated round-robin one pass at a time and
//                issue read requests over a valid/ready handshake.
//  Ports       : axi_aclk, axi_rst           - clock, sync active-high reset
//                ch_addr_low/high            - per-channel range (inclusive)
//                ch_replay_count             - per-channel pass count
//                ch_start/ch_stop            - per-channel control pulses
//                ch_busy/done/err/loops      - per-channel status
//                mem_rd_valid/ready/addr/ch/last - read-request handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module replay_sequencer_mc
    import replay_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int ADDR_WIDTH  = 19,
    parameter int COUNT_WIDTH = 32
) (
    input  wire logic                            axi_aclk,
    input  wire logic                            axi_rst,
    input  wire logic [NUM_CH*ADDR_WIDTH-1:0]    ch_addr_low,
    input  wire logic [NUM_CH*ADDR_WIDTH-1:0]    ch_addr_high,
    input  wire logic [NUM_CH*COUNT_WIDTH-1:0]   ch_replay_count,
    input  wire logic [NUM_CH-1:0]               ch_start,
    input  wire logic [NUM_CH-1:0]               ch_stop,
    output logic      [NUM_CH-1:0]               ch_busy,
    output logic      [NUM_CH-1:0]               ch_done,
    output logic      [NUM_CH-1:0]               ch_err,
    output logic      [NUM_CH*COUNT_WIDTH-1:0]   ch_loops,
    output logic                                 mem_rd_valid,
    input  wire logic                            mem_rd_ready,
    output logic      [ADDR_WIDTH-1:0]           mem_rd_addr,
    output logic      [ch_idx_w(NUM_CH)-1:0]     mem_rd_ch,
    output logic                                 mem_rd_last
);

    localparam int CH_IDX_W = ch_idx_w(NUM_CH);

    seq_state_e              r_state, w_state_nxt;
    logic [NUM_CH-1:0]       r_busy, r_done, r_err;
    logic [COUNT_WIDTH-1:0]  r_loops [NUM_CH];
    logic [COUNT_WIDTH-1:0]  r_count [NUM_CH];
    logic [ADDR_WIDTH-1:0]   r_addr, r_high;
    logic [CH_IDX_W-1:0]     r_gidx;
    logic                    r_stop_lat;

    logic                    w_arb_valid, w_accept, w_hs, w_last, w_stop_eff;
    logic                    w_count_hit;
    logic [NUM_CH-1:0]       w_arb_grant, w_granted;
    logic [CH_IDX_W-1:0]     w_arb_idx;
    logic [COUNT_WIDTH-1:0]  w_loops_inc;

    // A busy channel is pending whenever it does not hold the grant. A stop
    // arriving this cycle masks the request so a dying channel is never won.
    rr_arbiter #(.N(NUM_CH), .IDX_W(CH_IDX_W)) u_arb (
        .clk         (axi_aclk),
        .rst         (axi_rst),
        .i_req       (r_busy & ~ch_stop),
        .i_accept    (w_accept),
        .o_valid     (w_arb_valid),
        .o_grant     (w_arb_grant),
        .o_grant_idx (w_arb_idx)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // ---------------- FSM: next state and decode ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_hs        = 1'b0;
        w_granted   = '0;
        w_last      = (r_addr == r_high);
        w_stop_eff  = r_stop_lat | ch_stop[r_gidx];
        w_loops_inc = COUNT_WIDTH'(sat_inc(64'(r_loops[r_gidx]), COUNT_WIDTH));
        w_count_hit = (r_count[r_gidx] != '0) && (w_loops_inc == r_count[r_gidx]);
        case (r_state)
            ST_IDLE: begin
                if (w_arb_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_granted[r_gidx] = 1'b1;
                if (mem_rd_ready) begin
                    w_hs = 1'b1;
                    // Grant is released at every pass end, finished or not,
                    // so other channels get a turn between passes.
                    if (w_stop_eff || w_last) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- Request datapath ----------------
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            r_addr     <= '0;
            r_high     <= '0;
            r_gidx     <= '0;
            r_stop_lat <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= ch_addr_low [int'(w_arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_high     <= ch_addr_high[int'(w_arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
            r_gidx     <= w_arb_idx;
            r_stop_lat <= 1'b0;
        end else if (r_state == ST_ISSUE) begin
            // Stop is held until the in-flight beat handshakes.
            if (ch_stop[r_gidx]) r_stop_lat <= 1'b1;
            if (w_hs && !w_last) r_addr <= r_addr + 1'b1;
        end
    end

    // ---------------- Per-channel status ----------------
    always_ff @(posedge axi_aclk) begin
        if (axi_rst) begin
            r_busy <= '0;
            r_done <= '0;
            r_err  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_loops[i] <= '0;
                r_count[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!r_busy[i]) begin
                    // Stop wins over a simultaneous start on an idle channel.
                    if (ch_start[i] && !ch_stop[i]) begin
                        r_loops[i] <= '0;
                        if (ch_addr_low[i*ADDR_WIDTH +: ADDR_WIDTH] <=
                            ch_addr_high[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                            r_busy[i]  <= 1'b1;
                            r_done[i]  <= 1'b0;
                            r_err[i]   <= 1'b0;
                            r_count[i] <= ch_replay_count[i*COUNT_WIDTH +: COUNT_WIDTH];
                        end else begin
                            r_err[i]  <= 1'b1;
                            r_done[i] <= 1'b1;
                        end
                    end
                end else if (w_granted[i]) begin
                    if (w_hs) begin
                        // A beat that closes the range completes a full pass,
                        // even if a stop is pending.
                        if (w_last) r_loops[i] <= w_loops_inc;
                        if (w_stop_eff || (w_last && w_count_hit)) begin
                            r_busy[i] <= 1'b0;
                            r_done[i] <= 1'b1;
                        end
                    end
                end else if (ch_stop[i]) begin
                    r_busy[i] <= 1'b0;
                    r_done[i] <= 1'b1;
                end
            end
        end
    end

    // ---------------- Outputs ----------------
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_loops[i*COUNT_WIDTH +: COUNT_WIDTH] = r_loops[i];
        end
    end

    assign ch_busy      = r_busy;
    assign ch_done      = r_done;
    assign ch_err       = r_err;
    assign mem_rd_valid = (r_state == ST_ISSUE);
    assign mem_rd_addr  = r_addr;
    assign mem_rd_ch    = r_gidx;
    assign mem_rd_last  = (r_state == ST_ISSUE) && w_last;

endmodule : replay_sequencer_mc
`default_nettype wire

// File: tb/tb_replay_sequencer_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_replay_sequencer_mc
//  Description : Directed self-checking bench for replay_sequencer_mc with
//                NUM_CH=4, ADDR_WIDTH=19, COUNT_WIDTH=32.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_replay_sequencer_mc;

    localparam int NC = 4;
    localparam int AW = 19;
    localparam int CW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC*AW-1:0]  low, high;
    logic [NC*CW-1:0]  cnt;
    logic [NC-1:0]     start, stop;
    logic [NC-1:0]     busy, done, err;
    logic [NC*CW-1:0]  loops;
    logic              valid, ready, last;
    logic [AW-1:0]     addr;
    logic [1:0]        ch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    replay_sequencer_mc #(.NUM_CH(NC), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
        .axi_aclk        (clk),
        .axi_rst         (rst),
        .ch_addr_low     (low),
        .ch_addr_high    (high),
        .ch_replay_count (cnt),
        .ch_start        (start),
        .ch_stop         (stop),
        .ch_busy         (busy),
        .ch_done         (done),
        .ch_err          (err),
        .ch_loops        (loops),
        .mem_rd_valid    (valid),
        .mem_rd_ready    (ready),
        .mem_rd_addr     (addr),
        .mem_rd_ch       (ch),
        .mem_rd_last     (last)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input int lo, input int hi, input int c);
        low [i*AW +: AW] = AW'(lo);
        high[i*AW +: AW] = AW'(hi);
        cnt [i*CW +: CW] = CW'(c);
    endtask

    // Checks the request currently on the bus, then advances one cycle.
    task automatic beat(input string tag, input int a, input int c, input bit l);
        chk({tag, ".valid"}, 64'(valid), 64'd1);
        chk({tag, ".addr"},  64'(addr),  64'(a));
        chk({tag, ".ch"},    64'(ch),    64'(c));
        chk({tag, ".last"},  64'(last),  64'(l));
        tick();
    endtask

    task automatic idle(input string tag);
        chk({tag, ".idle"}, 64'(valid), 64'd0);
        tick();
    endtask

    function automatic logic [CW-1:0] lp(input int i);
        return loops[i*CW +: CW];
    endfunction

    initial begin
        rst = 1'b1; low = '0; high = '0; cnt = '0;
        start = '0; stop = '0; ready = 1'b1;

        // ---- Reset, with a start pulse that reset must override ----
        set_ch(1, 'h5, 'h6, 1);
        start = 4'b0010;
        tick(); tick();
        start = '0;
        chk("rst.valid", 64'(valid), 64'd0);
        chk("rst.busy",  64'(busy),  64'd0);
        chk("rst.done",  64'(done),  64'd0);
        chk("rst.err",   64'(err),   64'd0);
        chk("rst.loops", 64'(lp(1)), 64'd0);
        chk("rst.last",  64'(last),  64'd0);
        rst = 1'b0;
        tick();

        // ---- ch0 0x10..0x13, two passes ----
        set_ch(0, 'h10, 'h13, 2);
        start = 4'b0001;
        tick();
        start = '0;
        chk("p2.busy_n1",  64'(busy[0]), 64'd1);
        chk("p2.valid_n1", 64'(valid),   64'd0);
        tick();
        beat("p2.a", 'h10, 0, 0); beat("p2.b", 'h11, 0, 0);
        beat("p2.c", 'h12, 0, 0); beat("p2.d", 'h13, 0, 1);
        chk("p2.loops_mid", 64'(lp(0)), 64'd1);
        idle("p2.gap");
        beat("p2.e", 'h10, 0, 0); beat("p2.f", 'h11, 0, 0);
        beat("p2.g", 'h12, 0, 0); beat("p2.h", 'h13, 0, 1);
        chk("p2.valid_end", 64'(valid),   64'd0);
        chk("p2.done",      64'(done[0]), 64'd1);
        chk("p2.busy",      64'(busy[0]), 64'd0);
        chk("p2.loops",     64'(lp(0)),   64'd2);

        // ---- ch1/ch2 one-word regions interleave per pass ----
        set_ch(1, 'h40, 'h40, 2);
        set_ch(2, 'h50, 'h50, 2);
        start = 4'b0110;
        tick();
        start = '0;
        tick();
        beat("rr.1", 'h40, 1, 1); idle("rr.g1");
        beat("rr.2", 'h50, 2, 1); idle("rr.g2");
        beat("rr.3", 'h40, 1, 1); idle("rr.g3");
        beat("rr.4", 'h50, 2, 1);
        chk("rr.done", 64'(done[2:1]), 64'b11);
        chk("rr.loops1", 64'(lp(1)), 64'd2);
        chk("rr.loops2", 64'(lp(2)), 64'd2);

        // ---- start+stop on idle ch2: no change ----
        start = 4'b0100; stop = 4'b0100;
        tick();
        start = '0; stop = '0;
        chk("ss.busy",  64'(busy[2]), 64'd0);
        chk("ss.done",  64'(done[2]), 64'd1);
        chk("ss.loops", 64'(lp(2)),   64'd2);
        chk("ss.valid", 64'(valid),   64'd0);

        // ---- backpressure: ready low 5 cycles mid-pass ----
        set_ch(0, 'h60, 'h63, 1);
        start = 4'b0001;
        tick();
        start = '0;
        chk("bp.done_clr", 64'(done[0]), 64'd0);
        tick();
        beat("bp.a", 'h60, 0, 0);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp.hold_valid", 64'(valid), 64'd1);
            chk("bp.hold_addr",  64'(addr),  64'h61);
            chk("bp.hold_ch",    64'(ch),    64'd0);
            tick();
        end
        ready = 1'b1;
        beat("bp.b", 'h61, 0, 0); beat("bp.c", 'h62, 0, 0); beat("bp.d", 'h63, 0, 1);
        chk("bp.done",  64'(done[0]), 64'd1);
        chk("bp.loops", 64'(lp(0)),   64'd1);

        // ---- ch3 infinite, stop at 0x22 while stalled ----
        set_ch(3, 'h20, 'h2F, 0);
        start = 4'b1000;
        tick();
        start = '0;
        tick();
        beat("st.a", 'h20, 3, 0); beat("st.b", 'h21, 3, 0);
        ready = 1'b0; stop = 4'b1000;
        chk("st.v0", 64'(addr), 64'h22);
        tick();
        stop = '0;
        chk("st.v1",   64'(valid), 64'd1);
        chk("st.a1",   64'(addr),  64'h22);
        chk("st.busy", 64'(busy[3]), 64'd1);
        tick();
        ready = 1'b1;
        chk("st.a2", 64'(addr), 64'h22);
        tick();
        chk("st.valid", 64'(valid),   64'd0);
        chk("st.done",  64'(done[3]), 64'd1);
        chk("st.busy0", 64'(busy[3]), 64'd0);
        chk("st.loops", 64'(lp(3)),   64'd0);
        tick();
        chk("st.quiet", 64'(valid), 64'd0);

        // ---- bad range on ch1 ----
        set_ch(1, 'h30, 'h2F, 1);
        start = 4'b0010;
        tick();
        start = '0;
        chk("er.err",  64'(err[1]),  64'd1);
        chk("er.done", 64'(done[1]), 64'd1);
        chk("er.busy", 64'(busy[1]), 64'd0);
        tick();
        chk("er.valid", 64'(valid), 64'd0);

        // ---- reset mid-pass, then restart ----
        set_ch(0, 'h70, 'h7F, 0);
        start = 4'b0001;
        tick();
        start = '0;
        tick();
        beat("mr.a", 'h70, 0, 0);
        chk("mr.pre", 64'(valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr.valid", 64'(valid), 64'd0);
        chk("mr.busy",  64'(busy),  64'd0);
        chk("mr.done",  64'(done),  64'd0);
        chk("mr.err",   64'(err),   64'd0);
        chk("mr.loops", 64'(loops), 64'd0);
        start = 4'b0001;
        tick();
        start = '0;
        tick();
        beat("mr.b", 'h70, 0, 0);
        stop = 4'b0001;
        beat("mr.c", 'h71, 0, 0);
        stop = '0;
        chk("mr.stop_valid", 64'(valid),   64'd0);
        chk("mr.stop_done",  64'(done[0]), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_replay_sequencer_mc
`default_nettype wire
